mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_wb_stage_if.sv | 31 +++
 rtl/mem_wb_pipe_reg.sv | 47 ++++
 rtl/mem_wb_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared types and widths for the MEM/WB pipeline stage.
//                Holds the access-FSM state encoding and the packed MEM/WB
//                register record used by the stage and its pipe register.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // IDLE: decode the EX/MEM op; ACCESS: data-memory request outstanding.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
    } mem_wb_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_if
//  Description : Data-memory request/completion bus of the MEM stage.
//                master : the pipeline stage (drives request, address, data)
//                slave  : the data memory (drives ack and read data)
//                dmem_rdata is only meaningful while dmem_ack is high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
    import mem_stage_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface : mem_wb_stage_if
`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pipe_reg
//  Description : MEM/WB pipeline register.
//                load   : capture d_in on the next rising edge
//                bubble : capture an all-zero record (no write-back)
//                neither: hold the current contents
//                load has priority over bubble. Cleared asynchronously by
//                the active-low reset.
//  Ports       : clk, reset (async, active-low), load, bubble, d_in, q_out
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d_in,
    output mem_wb_t q_out
);

    mem_wb_t mw_d;
    mem_wb_t mw_q;

    always_comb begin
        mw_d = mw_q;
        if (load) begin
            mw_d = d_in;
        end else if (bubble) begin
            mw_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mw_q <= '0;
        end else begin
            mw_q <= mw_d;
        end
    end

    assign q_out = mw_q;

endmodule : mem_wb_pipe_reg
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM pipeline stage with a two-state access FSM and the
//                MEM/WB register. Non-memory ops pass to MEM/WB in one cycle.
//                Loads/stores spend one IDLE cycle (bubble issued) and then
//                stay in ACCESS, holding the upstream stage via stall_mem,
//                until dmem_ack returns. Branch redirect is combinational.
//  Ports       : clk, reset (async, active-low)
//                EX/MEM inputs  : *_ex_mem control/data, Reg_dest_op_ex_mem
//                dmem           : data-memory bus (mem_wb_stage_if.master)
//                pc_src, pc_branch_target : fetch redirect
//                stall_mem      : upstream hold
//                *_mem_wb       : MEM/WB register outputs
//                mem_err        : sticky access-timeout flag
//  Options     : MEM_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES
//                ACCESS cycles without ack and set mem_err. When undefined
//                the access waits indefinitely and mem_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_ex_mem,
    input  logic              memRead_ex_mem,
    input  logic              memWrite_ex_mem,
    input  logic              regwrite_ex_mem,
    input  logic              MemtoReg_ex_mem,
    input  logic [ADDR_W-1:0] pc_branch_target_ex_mem,
    input  logic [DATA_W-1:0] result_ex_mem,
    input  logic [DATA_W-1:0] B_ex_mem,
    input  logic              zero_flag_ex_mem,
    input  logic [REG_W-1:0]  Reg_dest_op_ex_mem,
    mem_wb_stage_if.master    dmem,
    output logic              pc_src,
    output logic [ADDR_W-1:0] pc_branch_target,
    output logic              stall_mem,
    output logic              regwrite_mem_wb,
    output logic              MemtoReg_mem_wb,
    output logic [DATA_W-1:0] read_data_mem_wb,
    output logic [DATA_W-1:0] result_mem_wb,
    output logic [REG_W-1:0]  Reg_dest_op_mem_wb,
    output logic              mem_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_wb_stage: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e state_d;
    mem_state_e state_q;

    logic    w_mem_op;
    logic    w_in_access;
    logic    w_ack;
    logic    w_timeout;
    logic    w_load;
    logic    w_bubble;
    mem_wb_t w_wb_d;
    mem_wb_t w_wb_q;

    assign w_mem_op    = memRead_ex_mem | memWrite_ex_mem;
    assign w_in_access = (state_q == ST_ACCESS);
    // Ack outside ACCESS is meaningless and must not complete anything.
    assign w_ack       = w_in_access & dmem.dmem_ack;

    // ------------------------------------------------------------------
    // Optional access timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_d;
    logic             err_q;

    // The counter holds the number of completed no-ack ACCESS cycles, so
    // the cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    assign w_timeout = w_in_access & ~dmem.dmem_ack & (cnt_q == C_TO_LAST);

    always_comb begin
        cnt_d = '0;
        if (w_in_access && !dmem.dmem_ack && !w_timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = err_q | w_timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        w_load   = 1'b0;
        w_bubble = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_mem_op) begin
                    state_d  = ST_ACCESS;
                    w_bubble = 1'b1;
                end else begin
                    w_load = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (w_ack) begin
                    state_d = ST_IDLE;
                    w_load  = 1'b1;
                end else if (w_timeout) begin
                    state_d  = ST_IDLE;
                    w_bubble = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Writes (including read+write collisions) never return read data.
    always_comb begin
        w_wb_d.regwrite  = regwrite_ex_mem;
        w_wb_d.memtoreg  = MemtoReg_ex_mem;
        w_wb_d.read_data = (w_in_access && !memWrite_ex_mem) ? dmem.dmem_rdata : '0;
        w_wb_d.result    = result_ex_mem;
        w_wb_d.rd        = Reg_dest_op_ex_mem;
    end

    mem_wb_pipe_reg u_pipe_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .bubble (w_bubble),
        .d_in   (w_wb_d),
        .q_out  (w_wb_q)
    );

    assign regwrite_mem_wb    = w_wb_q.regwrite;
    assign MemtoReg_mem_wb    = w_wb_q.memtoreg;
    assign read_data_mem_wb   = w_wb_q.read_data;
    assign result_mem_wb      = w_wb_q.result;
    assign Reg_dest_op_mem_wb = w_wb_q.rd;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    assign dmem.dmem_req   = w_in_access;
    assign dmem.dmem_we    = memWrite_ex_mem;
    assign dmem.dmem_addr  = result_ex_mem;
    assign dmem.dmem_wdata = B_ex_mem;

    // Released in the completing cycle so EX/MEM advances exactly once.
    assign stall_mem        = w_mem_op & ~(w_in_access & (w_ack | w_timeout));
    assign pc_src           = branch_ex_mem & zero_flag_ex_mem;
    assign pc_branch_target = pc_branch_target_ex_mem;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage: table of single-cycle
//                ALU/branch vectors, hand sequences for load, store, reset
//                and timeout, then randomized traffic against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_wb_stage;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        br, zr, mr, mw, rw, m2r;
    logic [31:0] tgt, res, bval;
    logic [4:0]  rd;

    logic        pc_src, stall_mem, regwrite_mem_wb, MemtoReg_mem_wb, mem_err;
    logic [31:0] pc_branch_target, read_data_mem_wb, result_mem_wb;
    logic [4:0]  Reg_dest_op_mem_wb;

    int checks   = 0;
    int failures = 0;

    mem_wb_stage_if dmem_bus ();

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .branch_ex_mem           (br),
        .memRead_ex_mem          (mr),
        .memWrite_ex_mem         (mw),
        .regwrite_ex_mem         (rw),
        .MemtoReg_ex_mem         (m2r),
        .pc_branch_target_ex_mem (tgt),
        .result_ex_mem           (res),
        .B_ex_mem                (bval),
        .zero_flag_ex_mem        (zr),
        .Reg_dest_op_ex_mem      (rd),
        .dmem                    (dmem_bus),
        .pc_src                  (pc_src),
        .pc_branch_target        (pc_branch_target),
        .stall_mem               (stall_mem),
        .regwrite_mem_wb         (regwrite_mem_wb),
        .MemtoReg_mem_wb         (MemtoReg_mem_wb),
        .read_data_mem_wb        (read_data_mem_wb),
        .result_mem_wb           (result_mem_wb),
        .Reg_dest_op_mem_wb      (Reg_dest_op_mem_wb),
        .mem_err                 (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_br, input logic i_zr, input logic i_mr, input logic i_mw,
                         input logic i_rw, input logic i_m2r, input logic [31:0] i_tgt,
                         input logic [31:0] i_res, input logic [31:0] i_b, input logic [4:0] i_rd);
        br = i_br; zr = i_zr; mr = i_mr; mw = i_mw; rw = i_rw; m2r = i_m2r;
        tgt = i_tgt; res = i_res; bval = i_b; rd = i_rd;
    endtask

    task automatic set_ack(input logic a, input logic [31:0] d);
        dmem_bus.dmem_ack   = a;
        dmem_bus.dmem_rdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic chk_wb(input string nm, input logic e_rw, input logic e_m2r,
                          input logic [31:0] e_rdat, input logic [31:0] e_res, input logic [4:0] e_rd);
        chk({nm, "_regwrite"}, 32'(regwrite_mem_wb), 32'(e_rw));
        chk({nm, "_memtoreg"}, 32'(MemtoReg_mem_wb), 32'(e_m2r));
        chk({nm, "_rdata"}, read_data_mem_wb, e_rdat);
        chk({nm, "_result"}, result_mem_wb, e_res);
        chk({nm, "_rd"}, 32'(Reg_dest_op_mem_wb), 32'(e_rd));
    endtask

    typedef struct {
        logic        br, zr, rw, m2r;
        logic [31:0] tgt, res;
        logic [4:0]  rd;
        logic        exp_pc;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_rw, exp_m2r;
    } vec_t;

    vec_t vecs[6];

    // Reference-model state for the randomized section.
    int      age;
    logic    m_err;
    mem_wb_t m_wb;

    initial begin
        int st_cnt, rq_cnt;
        logic hold;

        set_ack(1'b0, 32'h0);
        // Load op presented during reset: stall must reflect IDLE decode.
        drive(0, 0, 1, 0, 1, 1, 32'h0, 32'h100, 32'h0, 5'd3);
        reset = 1'b0;
        #3;
        chk("rst_req", 32'(dmem_bus.dmem_req), 32'h0);
        chk("rst_stall_idle", 32'(stall_mem), 32'h1);
        chk_wb("rst", 0, 0, 32'h0, 32'h0, 5'd0);
        chk("rst_err", 32'(mem_err), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        #9;
        reset = 1'b1;
        tick();

        // ---------------- table-driven ALU / branch vectors ----------------
        vecs[0] = '{0, 0, 1, 0, 32'h0,         32'h0000_0010, 5'd5,  0, 32'h0000_0010, 5'd5,  1, 0};
        vecs[1] = '{1, 1, 0, 0, 32'h0000_0040, 32'hABCD_0000, 5'd0,  1, 32'hABCD_0000, 5'd0,  0, 0};
        vecs[2] = '{1, 0, 1, 0, 32'h0000_0040, 32'h0000_0001, 5'd31, 0, 32'h0000_0001, 5'd31, 1, 0};
        vecs[3] = '{0, 1, 1, 1, 32'h0000_1234, 32'hFFFF_FFFF, 5'd31, 0, 32'hFFFF_FFFF, 5'd31, 1, 1};
        vecs[4] = '{0, 0, 0, 0, 32'h0,         32'h0,         5'd0,  0, 32'h0,         5'd0,  0, 0};
        vecs[5] = '{1, 1, 1, 0, 32'hFFFF_FFFC, 32'h0000_0007, 5'd1,  1, 32'h0000_0007, 5'd1,  1, 0};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].br, vecs[i].zr, 0, 0, vecs[i].rw, vecs[i].m2r,
                  vecs[i].tgt, vecs[i].res, 32'h5A5A_5A5A, vecs[i].rd);
            set_ack(1'b1, 32'hFFFF_0000);   // ack outside ACCESS is ignored
            @(negedge clk);
            chk($sformatf("vec%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_target", i), pc_branch_target, vecs[i].tgt);
            chk($sformatf("vec%0d_stall", i), 32'(stall_mem), 32'h0);
            chk($sformatf("vec%0d_req", i), 32'(dmem_bus.dmem_req), 32'h0);
            tick();
            chk_wb($sformatf("vec%0d", i), vecs[i].exp_rw, vecs[i].exp_m2r, 32'h0,
                   vecs[i].exp_res, vecs[i].exp_rd);
        end
        set_ack(1'b0, 32'h0);

        // ---------------- load, ack in third ACCESS cycle ----------------
        drive(0, 0, 1, 0, 1, 1, 32'h0, 32'h100, 32'h0, 5'd7);
        st_cnt = 0; rq_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            set_ack(c == 3, (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD);
            @(negedge clk);
            if (stall_mem) st_cnt++;
            if (dmem_bus.dmem_req) rq_cnt++;
            if (c == 0) begin
                chk("ld_addr", dmem_bus.dmem_addr, 32'h100);
                chk("ld_we", 32'(dmem_bus.dmem_we), 32'h0);
            end
            tick();
            if (c == 0) chk_wb("ld_bubble", 0, 0, 32'h0, 32'h0, 5'd0);
        end
        chk("ld_stall_cycles", 32'(st_cnt), 32'd3);
        chk("ld_req_cycles", 32'(rq_cnt), 32'd3);
        chk_wb("ld_done", 1, 1, 32'hDEAD_BEEF, 32'h100, 5'd7);
        set_ack(1'b0, 32'h0);

        // ---------------- store, immediate ack ----------------
        drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h200, 32'h1234, 5'd0);
        st_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            set_ack(c == 1, 32'h5555_5555);
            @(negedge clk);
            if (stall_mem) st_cnt++;
            chk($sformatf("st%0d_we", c), 32'(dmem_bus.dmem_we), 32'h1);
            chk($sformatf("st%0d_wdata", c), dmem_bus.dmem_wdata, 32'h1234);
            tick();
        end
        chk("st_stall_cycles", 32'(st_cnt), 32'd1);
        chk_wb("st_done", 0, 0, 32'h0, 32'h200, 5'd0);

        // ---------------- read+write collision behaves as write ----------------
        drive(0, 0, 1, 1, 0, 0, 32'h0, 32'h300, 32'h77, 5'd2);
        set_ack(1'b0, 32'h0);
        @(negedge clk);
        chk("rw_we", 32'(dmem_bus.dmem_we), 32'h1);
        tick();
        set_ack(1'b1, 32'h9999_9999);
        tick();
        chk_wb("rw_done", 0, 0, 32'h0, 32'h300, 5'd2);
        set_ack(1'b0, 32'h0);

        // ---------------- async reset clears MEM/WB without an edge ----------------
        drive(0, 0, 0, 0, 1, 1, 32'h0, 32'hCAFE, 32'h0, 5'd9);
        tick();
        chk("pre_rst_result", result_mem_wb, 32'hCAFE);
        #2 reset = 1'b0;
        #1 chk_wb("async_rst", 0, 0, 32'h0, 32'h0, 5'd0);
        #1 reset = 1'b1;

        // ---------------- reset mid-ACCESS aborts the request ----------------
        drive(0, 0, 1, 0, 1, 1, 32'h0, 32'h400, 32'h0, 5'd4);
        tick();
        #1 chk("acc_req_before_rst", 32'(dmem_bus.dmem_req), 32'h1);
        reset = 1'b0;
        #1 chk("acc_req_after_rst", 32'(dmem_bus.dmem_req), 32'h0);
        set_ack(1'b1, 32'h1111_1111);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(dmem_bus.dmem_req), 32'h0);
        chk("post_rst_stall", 32'(stall_mem), 32'h1);
        tick();
        chk_wb("post_rst_ack_ignored", 0, 0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        chk("post_rst_req2", 32'(dmem_bus.dmem_req), 32'h1);
        tick();
        chk_wb("post_rst_done", 1, 1, 32'h1111_1111, 32'h400, 5'd4);
        set_ack(1'b0, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // ---------------- timeout abort after TO ACCESS cycles ----------------
        drive(0, 0, 1, 0, 1, 1, 32'h0, 32'h500, 32'h0, 5'd6);
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk);
            chk($sformatf("to%0d_stall", c), 32'(stall_mem), (c == TO) ? 32'h0 : 32'h1);
            tick();
        end
        chk("to_err", 32'(mem_err), 32'h1);
        chk_wb("to_bubble", 0, 0, 32'h0, 32'h0, 5'd0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        chk("to_err_sticky", 32'(mem_err), 32'h1);
`else
        chk("no_timeout_err", 32'(mem_err), 32'h0);
`endif

        // ---------------- randomized traffic vs. reference model ----------------
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        do_reset();
        age   = 0;
        m_err = 1'b0;
        m_wb  = '0;
        hold  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic    mem_op, e_req, e_stall, done, tmo;
            logic    ack;
            logic [31:0] rdat;
            mem_wb_t got;
            if (!hold) begin
                int kind;
                kind = $urandom_range(0, 4);
                drive($urandom_range(0, 1), $urandom_range(0, 1),
                      (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom, $urandom, $urandom, 5'($urandom));
            end
            ack  = ($urandom_range(0, 2) == 0);
            rdat = $urandom;
            set_ack(ack, rdat);
            @(negedge clk);
            // An instruction presented for its first cycle only decodes; a
            // memory op requests from its second cycle until it completes.
            mem_op  = mr | mw;
            e_req   = mem_op && (age > 0);
            done    = e_req && ack;
`ifdef MEM_TIMEOUT_EN
            tmo     = e_req && !ack && (age == TO);
`else
            tmo     = 1'b0;
`endif
            e_stall = mem_op && !done && !tmo;
            chk("rnd_stall", 32'(stall_mem), 32'(e_stall));
            chk("rnd_req", 32'(dmem_bus.dmem_req), 32'(e_req));
            chk("rnd_pc_src", 32'(pc_src), 32'(br & zr));
            chk("rnd_we", 32'(dmem_bus.dmem_we), 32'(mw));
            chk("rnd_addr", dmem_bus.dmem_addr, res);
            chk("rnd_wdata", dmem_bus.dmem_wdata, bval);
            if (!mem_op)
                m_wb = '{rw, m2r, 32'h0, res, rd};
            else if (done)
                m_wb = '{rw, m2r, mw ? 32'h0 : rdat, res, rd};
            else if (age == 0 || tmo)
                m_wb = '0;
            m_err = m_err | tmo;
            age   = e_stall ? age + 1 : 0;
            hold  = e_stall;
            tick();
            got = '{regwrite_mem_wb, MemtoReg_mem_wb, read_data_mem_wb, result_mem_wb, Reg_dest_op_mem_wb};
            checks++;
            if (got !== m_wb) begin
                failures++;
                $display("FAIL rnd_wb cycle=%0d actual=%h required=%h", n, got, m_wb);
            end
            chk("rnd_err", 32'(mem_err), 32'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire
